mem_miss_sequencer: RTL and testbench
=====================================

Name: mem_miss_sequencer

Overview:
- Sequences the MEM stage's data-cache access for load/store instructions (LW, SW, LB, SB).
- On a hit, it completes the access in the same cycle.
- On a miss, it freezes the pipeline, optionally writes back the dirty victim line, fills the line from main memory after a fixed latency, then releases.
- Its `stall` output drives the control unit's `stall` input, and therefore `pc_we`.

Parameters:
- MEM_LATENCY, 4, main-memory block access time in cycles; legal range ≥1.
- CNT_W, $clog2(MEM_LATENCY+1), width of the latency down-counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_req  in  1  MEM-stage instruction is a memory instruction.
- mem_write  in  1  MEM-stage instruction is a store (SW/SB); qualified by mem_req.
- hit  in  1  cache tag match for the current MEM address.
- victim_dirty  in  1  indexed victim line is dirty.
- stall  out  1  freeze PC and pipeline registers.
- mem_block_we  out  1  main-memory block write (victim writeback).
- mem_addr_sel  out  1  0 = request address, 1 = victim tag address.
- cache_fill_we  out  1  write the fetched block into the cache line, and set valid.
- cache_word_we  out  1  store-hit word/byte write into the cache.
- cache_set_dirty  out  1  set dirty bit of the accessed line.
- cache_clr_dirty  out  1  clear dirty bit; asserted with cache_fill_we.
- miss_count  out  32  total misses (optional feature).
- wb_count  out  32  total writebacks (optional feature).

Behaviour:
- Interface: one clock, `clk`. Reset `reset` is synchronous and active-high.
- States: IDLE, WB, FILL, REFILL. Reset → IDLE, counter = 0, all outputs 0.
- IDLE, no request: mem_req=0 → all outputs 0.
- IDLE, load hit: mem_req=1, hit=1 → stall=0; data is read combinationally by the datapath.
- IDLE, store hit: mem_req=1, hit=1, mem_write=1 → cache_word_we=1 and cache_set_dirty=1 in the same cycle, stall=0.
- IDLE, miss: mem_req=1, hit=0 → stall=1 combinationally in the same cycle; cache_word_we=0; counter loads MEM_LATENCY-1.
  - Next state is WB if victim_dirty=1, else FILL.
- WB:
  - Outputs: stall=1, mem_block_we=1, mem_addr_sel=1.
  - Counter decrements each cycle. When counter==0 → FILL, counter reloads MEM_LATENCY-1.
- FILL:
  - Outputs: stall=1, mem_addr_sel=0. Counter decrements.
  - When counter==0 → REFILL.
- REFILL:
  - Outputs: stall=1, cache_fill_we=1, cache_clr_dirty=1 (single cycle). Next state → IDLE.
  - In the following IDLE cycle hit=1, so the original access completes through the hit path. A store then writes its word and sets dirty.
- stall is combinational in IDLE and registered-state-decoded elsewhere. It never glitches low inside WB/FILL/REFILL.
- Penalty:
  - Clean miss: MEM_LATENCY+2 stall cycles.
  - Dirty miss: 2*MEM_LATENCY+2 stall cycles.
- MEM_LATENCY=1: the counter loads 0, so WB and FILL each last exactly one cycle.
- mem_req, mem_write and victim_dirty are sampled only in IDLE. Changes during WB/FILL/REFILL are ignored; the pipeline is frozen, so it cannot change legally.
- If IDLE still sees hit=0 after REFILL (a datapath fault), a new miss sequence starts. There is no special case.
- Reset mid-sequence: next cycle is IDLE with all outputs 0 and the counter cleared. The in-progress writeback or fill is abandoned; no cache write occurs.
- Simultaneous reset and miss: reset wins.

Optional Feature:
- Macro: MEM_SEQ_PERF_COUNTERS_EN.
- Defined:
  - miss_count increments on every IDLE→WB/FILL transition.
  - wb_count increments on every IDLE→WB transition.
  - Both are 32-bit, wrap modulo 2^32, and clear on reset.
- Undefined: both ports remain present, tied to 0, with no counter flops.

Decomposition:
- Shared package mem_seq_pkg contains:
  - the state enum mem_seq_state_t {IDLE, WB, FILL, REFILL};
  - the MEM opcode localparams (LW, SW, LB, SB), shared with the control unit's mem-instruction decode;
  - the default MEM_LATENCY.
- One natural sub-module: latency_down_counter, with load, load value, decrement enable and zero flag, parameterized by CNT_W.

Test Plan:
- Load hit: reset, then mem_req=1, hit=1, mem_write=0 → stall=0, no write strobes, state stays IDLE.
- Store hit: mem_req=1, hit=1, mem_write=1 → cache_word_we=1 and cache_set_dirty=1 for exactly 1 cycle, stall=0.
- Clean load miss, MEM_LATENCY=4: hit=0, victim_dirty=0 → stall high 6 cycles, cache_fill_we pulses on cycle 6, then hit=1 releases stall; miss_count=1, wb_count=0.
- Dirty store miss, MEM_LATENCY=4: victim_dirty=1 → mem_block_we with mem_addr_sel=1 for 4 cycles, FILL 4 cycles, REFILL 1. Total 10 stall cycles, then a 1-cycle cache_word_we; wb_count=1.
- Reset during FILL (cycle 3 of a miss) → next cycle all outputs 0, state IDLE. A subsequent miss takes the full 6-cycle penalty.
- MEM_LATENCY=1, dirty miss → stall exactly 4 cycles; mem_block_we high 1 cycle, cache_fill_we high 1 cycle.

Source files
------------

// File: rtl/mem_miss_sequencer_pkg.sv
// mem_seq_pkg: shared FSM state type, MEM opcodes and default memory latency
package mem_seq_pkg;
  typedef enum logic [1:0] {IDLE, WB, FILL, REFILL} mem_seq_state_t;
  localparam logic [5:0] LW = 6'h23;
  localparam logic [5:0] SW = 6'h2b;
  localparam logic [5:0] LB = 6'h20;
  localparam logic [5:0] SB = 6'h28;
  localparam int MEM_LATENCY_DEF = 4;
endpackage

// File: rtl/mem_miss_sequencer_if.sv
// mem_miss_sequencer_if: MEM-stage request, cache control and perf-counter bundle
interface mem_miss_sequencer_if;
  logic        mem_req;
  logic        mem_write;
  logic        hit;
  logic        victim_dirty;
  logic        stall;
  logic        mem_block_we;
  logic        mem_addr_sel;
  logic        cache_fill_we;
  logic        cache_word_we;
  logic        cache_set_dirty;
  logic        cache_clr_dirty;
  logic [31:0] miss_count;
  logic [31:0] wb_count;
  modport master (
    output mem_req, mem_write, hit, victim_dirty,
    input  stall, mem_block_we, mem_addr_sel, cache_fill_we, cache_word_we,
           cache_set_dirty, cache_clr_dirty, miss_count, wb_count
  );
  modport slave (
    input  mem_req, mem_write, hit, victim_dirty,
    output stall, mem_block_we, mem_addr_sel, cache_fill_we, cache_word_we,
           cache_set_dirty, cache_clr_dirty, miss_count, wb_count
  );
endinterface

// File: rtl/mem_miss_sequencer_latency_down_counter.sv
// latency_down_counter: loadable down-counter with zero flag timing memory accesses
module latency_down_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // load has priority over decrement
  always_comb begin
    cnt_d = load ? load_val : dec ? cnt_q - 1'b1 : cnt_q;
  end
  // count register, cleared on reset
  always_ff @(posedge clk) begin
    cnt_q <= reset ? '0 : cnt_d;
  end
  assign zero = cnt_q == '0;
endmodule

// File: rtl/mem_miss_sequencer.sv
// mem_miss_sequencer: data-cache miss FSM (writeback, fill, refill); perf counters under MEM_SEQ_PERF_COUNTERS_EN
module mem_miss_sequencer
  import mem_seq_pkg::*;
#(
  parameter int MEM_LATENCY = MEM_LATENCY_DEF,
  parameter int CNT_W = $clog2(MEM_LATENCY + 1)
) (
  input logic clk,
  input logic reset,
  mem_miss_sequencer_if.slave bus
);
  mem_seq_state_t state_q, state_d;
  logic load, dec, zero;
  latency_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk),
    .reset(reset),
    .load(load),
    .load_val(CNT_W'(MEM_LATENCY - 1)),
    .dec(dec),
    .zero(zero)
  );
  // next state, counter control and cache/memory strobes
  always_comb begin
    state_d = state_q;
    load = 1'b0;
    dec = 1'b0;
    bus.stall = 1'b0;
    bus.mem_block_we = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.cache_fill_we = 1'b0;
    bus.cache_word_we = 1'b0;
    bus.cache_set_dirty = 1'b0;
    bus.cache_clr_dirty = 1'b0;
    case (state_q)
      IDLE: if (bus.mem_req) begin
        bus.cache_word_we = bus.hit && bus.mem_write;
        bus.cache_set_dirty = bus.hit && bus.mem_write;
        bus.stall = !bus.hit;
        load = !bus.hit;
        state_d = bus.hit ? IDLE : bus.victim_dirty ? WB : FILL;
      end
      WB: begin
        bus.stall = 1'b1;
        bus.mem_block_we = 1'b1;
        bus.mem_addr_sel = 1'b1;
        load = zero;
        dec = !zero;
        state_d = zero ? FILL : WB;
      end
      FILL: begin
        bus.stall = 1'b1;
        dec = !zero;
        state_d = zero ? REFILL : FILL;
      end
      default: begin
        bus.stall = 1'b1;
        bus.cache_fill_we = 1'b1;
        bus.cache_clr_dirty = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
  // state register
  always_ff @(posedge clk) begin
    state_q <= reset ? IDLE : state_d;
  end
`ifdef MEM_SEQ_PERF_COUNTERS_EN
  logic [31:0] miss_cnt_q, miss_cnt_d, wb_cnt_q, wb_cnt_d;
  logic miss_start;
  // count miss and writeback entries out of IDLE
  always_comb begin
    miss_start = state_q == IDLE && bus.mem_req && !bus.hit;
    miss_cnt_d = miss_cnt_q + 32'(miss_start);
    wb_cnt_d = wb_cnt_q + 32'(miss_start && bus.victim_dirty);
  end
  // perf counter registers
  always_ff @(posedge clk) begin
    miss_cnt_q <= reset ? '0 : miss_cnt_d;
    wb_cnt_q <= reset ? '0 : wb_cnt_d;
  end
  assign bus.miss_count = miss_cnt_q;
  assign bus.wb_count = wb_cnt_q;
`else
  assign bus.miss_count = '0;
  assign bus.wb_count = '0;
`endif
endmodule

// File: tb/tb_mem_miss_sequencer.sv
// tb_mem_miss_sequencer: directed checks of hit paths, clean/dirty misses, reset abort and latency 1
module tb_mem_miss_sequencer;
`ifdef MEM_SEQ_PERF_COUNTERS_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  mem_miss_sequencer_if ia();
  mem_miss_sequencer_if ib();
  mem_miss_sequencer #(.MEM_LATENCY(4)) ua (.clk(clk), .reset(reset), .bus(ia.slave));
  mem_miss_sequencer #(.MEM_LATENCY(1)) ub (.clk(clk), .reset(reset), .bus(ib.slave));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic r, input logic w, input logic h, input logic v);
    if (sel) begin
      ib.mem_req = r; ib.mem_write = w; ib.hit = h; ib.victim_dirty = v;
    end else begin
      ia.mem_req = r; ia.mem_write = w; ia.hit = h; ia.victim_dirty = v;
    end
  endtask

  // {stall, mem_block_we, mem_addr_sel, cache_fill_we, cache_word_we, cache_set_dirty, cache_clr_dirty}
  function automatic logic [6:0] outs(input bit sel);
    return sel ? {ib.stall, ib.mem_block_we, ib.mem_addr_sel, ib.cache_fill_we,
                  ib.cache_word_we, ib.cache_set_dirty, ib.cache_clr_dirty}
               : {ia.stall, ia.mem_block_we, ia.mem_addr_sel, ia.cache_fill_we,
                  ia.cache_word_we, ia.cache_set_dirty, ia.cache_clr_dirty};
  endfunction

  task automatic miss(input string tag, input bit sel, input logic wr, input logic vd,
                      input int exp_stall, input int exp_wb);
    logic [6:0] o;
    int ns, nwb, nas, nf, ncl, nww, fill_at;
    bit done;
    ns = 0; nwb = 0; nas = 0; nf = 0; ncl = 0; nww = 0; fill_at = 0; done = 0;
    o = '0;
    drive(sel, 1'b1, wr, 1'b0, vd);
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      o = outs(sel);
      if (!o[6]) done = 1;
      else begin
        ns++;
        if (o[5]) nwb++;
        if (o[4]) nas++;
        if (o[2]) nww++;
        if (o[0]) ncl++;
        if (o[3]) begin
          nf++;
          fill_at = ns;
          drive(sel, 1'b1, wr, 1'b1, vd);
        end
        @(posedge clk);
        #1;
      end
    end
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_stall"}, ns, exp_stall);
    check({tag, "_blk_we"}, nwb, exp_wb);
    check({tag, "_addr_sel"}, nas, exp_wb);
    check({tag, "_fill"}, nf, 1);
    check({tag, "_clr"}, ncl, 1);
    check({tag, "_fill_last"}, fill_at, exp_stall);
    check({tag, "_we_in_stall"}, nww, 0);
    check({tag, "_release"}, 32'(o), {25'd0, 4'b0000, wr, wr, 1'b0});
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs_a", 32'(outs(0)), 0);
    check("rst_outs_b", 32'(outs(1)), 0);
    check("rst_miss_cnt", ia.miss_count, 0);
    check("rst_wb_cnt", ia.wb_count, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    drive(0, 1, 0, 1, 0);
    #1 check("ld_hit", 32'(outs(0)), 0);
    @(posedge clk);
    #1 drive(0, 0, 0, 1, 0);
    #1 check("ld_hit_idle", 32'(outs(0)), 0);
    check("ld_hit_miss_cnt", ia.miss_count, 0);
    drive(0, 1, 1, 1, 0);
    #1 check("st_hit", 32'(outs(0)), 32'b0000110);
    @(posedge clk);
    #1 drive(0, 0, 0, 1, 0);
    #1 check("st_hit_1cyc", 32'(outs(0)), 0);
    miss("clean_ld", 0, 1'b0, 1'b0, 6, 0);
    check("clean_miss_cnt", ia.miss_count, PERF);
    check("clean_wb_cnt", ia.wb_count, 0);
    miss("dirty_st", 0, 1'b1, 1'b1, 10, 4);
    check("dirty_miss_cnt", ia.miss_count, 2 * PERF);
    check("dirty_wb_cnt", ia.wb_count, PERF);
    drive(0, 1, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("pre_rst_fill", 32'(outs(0)), 32'b1000000);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(0, 0, 0, 1, 0);
    #1 check("rst_abort_outs", 32'(outs(0)), 0);
    check("rst_abort_miss_cnt", ia.miss_count, 0);
    miss("after_rst", 0, 1'b0, 1'b0, 6, 0);
    check("after_rst_miss_cnt", ia.miss_count, PERF);
    miss("lat1_dirty", 1, 1'b1, 1'b1, 4, 1);
    check("lat1_miss_cnt", ib.miss_count, PERF);
    check("lat1_wb_cnt", ib.wb_count, PERF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
